// File: rtl/mem_loader.sv
// mem_loader: streams a valid/ready byte sequence into consecutive RAM cells while holding the CPU off the port.
// Define VERIFY_EN to add a read-back checksum pass that raises err on mismatch.
module mem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] adrs,
    output logic [DATA_W-1:0] data,
    output logic              wr_en,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t          state;
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] len;

    assign wr_en    = in_valid & in_ready;
    assign data     = in_ready ? in_data : '0;
    assign cpu_hold = busy;

`ifdef VERIFY_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] rsum;
    logic [ADDR_W:0]   vcount;
`else
    logic unused_q;
    assign unused_q = ^q;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            len      <= '0;
            in_ready <= 1'b0;
            adrs     <= BASE;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef VERIFY_EN
            sum      <= '0;
            rsum     <= '0;
            vcount   <= '0;
            err      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    len   <= length;
                    count <= '0;
                    adrs  <= BASE;
`ifdef VERIFY_EN
                    sum    <= '0;
                    rsum   <= '0;
                    vcount <= '0;
                    err    <= 1'b0;
`endif
                    if (length == '0) begin
                        state <= DONE;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: if (wr_en) begin
                    count <= count + 1'b1;
                    adrs  <= adrs + 1'b1;
`ifdef VERIFY_EN
                    sum <= sum + in_data;
`endif
                    if (count + 1'b1 == len) begin
                        in_ready <= 1'b0;
`ifdef VERIFY_EN
                        state <= VERIFY;
                        adrs  <= BASE;
`else
                        state <= DONE;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef VERIFY_EN
                VERIFY: begin
                    vcount <= vcount + 1'b1;
                    adrs   <= adrs + 1'b1;
                    rsum   <= rsum + q;
                    if (vcount + 1'b1 == len) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        err   <= (rsum + q) != sum;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench driving two loaders (BASE_ADDR 0 and 250) in lockstep, each with its own RAM model.
module tb_mem_loader;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] length = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       fill = 1'b0;
    logic       corrupt = 1'b0;

    logic       in_ready0, wr_en0, busy0, hold0, done0, err0;
    logic       in_ready1, wr_en1, busy1, hold1, done1, err1;
    logic [7:0] adrs0, data0, q0, adrs1, data1, q1;

    logic [7:0] ram0 [256];
    logic [7:0] ram1 [256];
    logic [7:0] pat  [256];

    typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
    wr_t sb0[$];
    wr_t sb1[$];

    int vec = 0;
    int miss = 0;
    int dcnt0 = 0;
    int dcnt1 = 0;

    always #5 clock = ~clock;

    mem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start), .length(length),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .adrs(adrs0), .data(data0), .wr_en(wr_en0), .q(q0),
        .busy(busy0), .cpu_hold(hold0), .done(done0), .err(err0));

    mem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(250)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start), .length(length),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .adrs(adrs1), .data(data1), .wr_en(wr_en1), .q(q1),
        .busy(busy1), .cpu_hold(hold1), .done(done1), .err(err1));

    // Corruption flips one bit on read of cell 1, which both loaders cover.
    assign q0 = ram0[adrs0] ^ ((corrupt && adrs0 == 8'd1) ? 8'h01 : 8'h00);
    assign q1 = ram1[adrs1] ^ ((corrupt && adrs1 == 8'd1) ? 8'h01 : 8'h00);

    always @(posedge clock) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) begin
                ram0[i] <= 8'hEE;
                ram1[i] <= 8'hEE;
            end
        end else begin
            if (wr_en0) ram0[adrs0] <= data0;
            if (wr_en1) ram1[adrs1] <= data1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        wr_t e;
        if (wr_en0) begin
            if (sb0.size() == 0) chk("u0 unexpected write", {adrs0, data0}, 32'hFFFF_FFFF);
            else begin
                e = sb0.pop_front();
                chk("u0 write", {adrs0, data0}, {e.a, e.d});
            end
        end
        if (wr_en1) begin
            if (sb1.size() == 0) chk("u1 unexpected write", {adrs1, data1}, 32'hFFFF_FFFF);
            else begin
                e = sb1.pop_front();
                chk("u1 write", {adrs1, data1}, {e.a, e.d});
            end
        end
        if (done0) dcnt0++;
        if (done1) dcnt1++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_fill();
        fill = 1'b1;
        tick();
        fill = 1'b0;
    endtask

    task automatic send(input int i, input int gap);
        logic rdy = 1'b0;
        logic [7:0] a1 = 8'(250 + i);
        in_valid = 1'b1;
        in_data  = pat[i];
        sb0.push_back('{a: 8'(i), d: pat[i]});
        sb1.push_back('{a: a1, d: pat[i]});
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            rdy = in_ready0;
            if (rdy) chk("cpu_hold during load", {hold0, hold1}, 2'b11);
            tick();
            if (rdy) break;
        end
        if (!rdy) chk("in_ready timeout", 0, 1);
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic run_load(input int n, input int gap);
        int d0 = dcnt0;
        int d1 = dcnt1;
        start  = 1'b1;
        length = 9'(n);
        tick();
        start  = 1'b0;
        length = 9'd5;
        for (int i = 0; i < n; i++) send(i, gap);
        for (int k = 0; k < 700 && dcnt0 == d0; k++) @(negedge clock);
        repeat (3) @(negedge clock);
        chk("done pulses u0", dcnt0 - d0, 1);
        chk("done pulses u1", dcnt1 - d1, 1);
        chk("busy after done", {busy0, busy1, hold0, hold1}, 0);
        chk("scoreboard drained", sb0.size() + sb1.size(), 0);
    endtask

    task automatic chk_ram(input int n);
        logic [7:0] a1;
        for (int i = 0; i < n; i++) begin
            a1 = 8'(250 + i);
            chk("ram0 cell", {8'(i), ram0[i]}, {8'(i), pat[i]});
            chk("ram1 cell", {a1, ram1[a1]}, {a1, pat[i]});
        end
    endtask

    task automatic set_pat8();
        logic [63:0] p = 64'h81_07_06_22_41_C0_05_03;
        for (int i = 0; i < 8; i++) pat[i] = p[63-8*i -: 8];
    endtask

    initial begin
        logic exp_err;
        int d0;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset in_ready", {in_ready0, in_ready1}, 0);
        chk("reset wr_en", {wr_en0, wr_en1}, 0);
        chk("reset busy/hold", {busy0, busy1, hold0, hold1}, 0);
        chk("reset done/err", {done0, done1, err0, err1}, 0);
        chk("reset adrs", {adrs0, adrs1}, {8'd0, 8'd250});
        chk("reset data", {data0, data1}, 0);

        do_fill();
        set_pat8();
        run_load(8, 0);
        chk_ram(8);
        chk("ram0 past end untouched", ram0[8], 8'hEE);
        chk("err clean load", {err0, err1}, 0);

        do_fill();
        run_load(8, 1);
        chk_ram(8);

        d0 = dcnt0;
        start  = 1'b1;
        length = 9'd0;
        tick();
        start = 1'b0;
        @(negedge clock);
        chk("len0 first cycle", {done0, done1, busy0, busy1, in_ready0}, 0);
        @(negedge clock);
        chk("len0 done pulse", {done0, done1, busy0, busy1, in_ready0}, 5'b11000);
        @(negedge clock);
        chk("len0 done once", {done0, done1}, 0);
        chk("len0 count", dcnt0 - d0, 1);

        do_fill();
        for (int i = 0; i < 10; i++) pat[i] = 8'(i);
        run_load(10, 0);
        chk("u1 wrap 255", ram1[255], 8'h05);
        chk("u1 wrap 0", ram1[0], 8'h06);
        chk("u1 wrap 3", ram1[3], 8'h09);
        chk("u1 below base", ram1[4], 8'hEE);
        chk_ram(10);

        do_fill();
        for (int i = 0; i < 256; i++) pat[i] = 8'(i) ^ 8'h5A;
        run_load(256, 0);
        chk_ram(256);

        do_fill();
        set_pat8();
        d0 = dcnt0;
        start  = 1'b1;
        length = 9'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(i, 0);
        reset_n = 1'b0;
        #2;
        chk("midload reset state", {busy0, busy1, in_ready0, in_ready1, wr_en0}, 0);
        chk("midload reset adrs", {adrs0, adrs1}, {8'd0, 8'd250});
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("midload no done", dcnt0 - d0, 0);
        chk("midload ram0 written", {ram0[0], ram0[1], ram0[2]}, {8'h81, 8'h07, 8'h06});
        chk("midload ram0 rest", ram0[3], 8'hEE);
        chk("midload ram1 written", {ram1[250], ram1[251], ram1[252], ram1[253]}, {8'h81, 8'h07, 8'h06, 8'hEE});

`ifdef VERIFY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        corrupt = 1'b1;
        run_load(8, 0);
        chk("err corrupted readback", {err0, err1}, {exp_err, exp_err});
        repeat (3) tick();
        chk("err holds", {err0, err1}, {exp_err, exp_err});
        corrupt = 1'b0;
        run_load(8, 0);
        chk("err good readback", {err0, err1}, 0);
        chk_ram(8);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
